// File: rtl/config_word_parser_pkg.sv
// -----------------------------------------------------------------------------
// config_parser_pkg
// Shared types and constants for the configuration word parser.
//   parser_state_e     : parser FSM states (HUNT, HEADER, DATA)
//   SYNC_WORD_DEFAULT  : word that arms the parser
//   DESYNC_COLUMN      : header column value that returns the parser to HUNT
//   HDR_* positions    : header field locations ([31:24] column, [23:16] index)
//   hdr_column/hdr_index: field extraction helpers
// -----------------------------------------------------------------------------
package config_parser_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2
   } parser_state_e;

   localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;
   localparam logic [7:0]  DESYNC_COLUMN     = 8'hFF;

   localparam int HDR_COL_MSB = 31;
   localparam int HDR_COL_LSB = 24;
   localparam int HDR_IDX_MSB = 23;
   localparam int HDR_IDX_LSB = 16;

   function automatic logic [7:0] hdr_column(input logic [31:0] word);
      return word[HDR_COL_MSB:HDR_COL_LSB];
   endfunction

   function automatic logic [7:0] hdr_index(input logic [31:0] word);
      return word[HDR_IDX_MSB:HDR_IDX_LSB];
   endfunction

endpackage

// File: rtl/config_word_parser_if.sv
// -----------------------------------------------------------------------------
// config_word_parser_if
// Self-write input stream and frame-write output bundle of the parser.
//   master : bitstream source / fabric side (drives SelfWrite*, observes frame)
//   slave  : the parser (consumes SelfWrite*, drives frame outputs)
// Signals: SelfWriteStrobe, SelfWriteData[31:0], FrameData[32*NUM_ROWS-1:0],
//          FrameColumn[7:0], FrameIndex[7:0], FrameStrobe, ConfigActive,
//          FormatError, and FrameCount[15:0] when CONFIG_FRAME_COUNTER_EN
//          is defined.
// -----------------------------------------------------------------------------
interface config_word_parser_if #(
   parameter int NUM_ROWS = 16
);
   logic                    SelfWriteStrobe;
   logic [31:0]             SelfWriteData;
   logic [32*NUM_ROWS-1:0]  FrameData;
   logic [7:0]              FrameColumn;
   logic [7:0]              FrameIndex;
   logic                    FrameStrobe;
   logic                    ConfigActive;
   logic                    FormatError;
`ifdef CONFIG_FRAME_COUNTER_EN
   logic [15:0]             FrameCount;
`endif

   modport master (
      output SelfWriteStrobe, SelfWriteData,
`ifdef CONFIG_FRAME_COUNTER_EN
      input  FrameCount,
`endif
      input  FrameData, FrameColumn, FrameIndex, FrameStrobe,
             ConfigActive, FormatError
   );

   modport slave (
      input  SelfWriteStrobe, SelfWriteData,
`ifdef CONFIG_FRAME_COUNTER_EN
      output FrameCount,
`endif
      output FrameData, FrameColumn, FrameIndex, FrameStrobe,
             ConfigActive, FormatError
   );

endinterface

// File: rtl/config_word_parser_assembler.sv
// -----------------------------------------------------------------------------
// config_frame_assembler
// Row counter, NUM_ROWS x 32 frame register and commit pulse.
//   CLK, resetn  : clock, asynchronous active-low reset
//   clr          : restart at row 0 (new header accepted)
//   wr_en        : data word accepted this cycle, written at row row_cnt
//   wr_data      : the data word
//   discard      : current frame is invalid, suppress the commit pulse
//   frame_data   : assembled frame, row r at [32r+31:32r]
//   last_row     : row counter points at the final row
//   frame_strobe : one-cycle pulse the cycle after the last row is written
// -----------------------------------------------------------------------------
module config_frame_assembler #(
   parameter int NUM_ROWS = 16
) (
   input  logic                   CLK,
   input  logic                   resetn,
   input  logic                   clr,
   input  logic                   wr_en,
   input  logic [31:0]            wr_data,
   input  logic                   discard,
   output logic [32*NUM_ROWS-1:0] frame_data,
   output logic                   last_row,
   output logic                   frame_strobe
);

   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   logic [ROW_W-1:0]              row_cnt_q;
   logic [NUM_ROWS-1:0][31:0]     data_q;

   assign last_row   = (row_cnt_q == ROW_W'(NUM_ROWS - 1));
   assign frame_data = data_q;

   // NOTE: the frame register is reset like any control flop because its
   // all-zero reset value is visible on FrameData.
   // NOTE: sequential state uses non-blocking assignments only so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         row_cnt_q    <= '0;
         data_q       <= '0;
         frame_strobe <= 1'b0;
      end else begin
         frame_strobe <= wr_en && last_row && !discard;
         if (clr) begin
            row_cnt_q <= '0;
         end else if (wr_en) begin
            data_q[row_cnt_q] <= wr_data;
            row_cnt_q         <= row_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/config_word_parser.sv
// -----------------------------------------------------------------------------
// config_word_parser
// Receiving end of the 32-bit self-write configuration port. Hunts for the
// sync word, decodes frame headers, collects NUM_ROWS data words per frame
// and emits one FrameStrobe per valid frame.
//   CLK     : system clock, rising edge
//   resetn  : asynchronous active-low reset
//   bus     : config_word_parser_if.slave (SelfWrite* in, Frame* out,
//             ConfigActive, FormatError)
// Optional: define CONFIG_FRAME_COUNTER_EN to add bus.FrameCount, a saturating
// count of committed frames cleared by each sync word accepted in HUNT.
// -----------------------------------------------------------------------------
module config_word_parser
   import config_parser_pkg::*;
#(
   parameter int          NUM_COLUMNS    = 16,
   parameter int          NUM_ROWS       = 16,
   parameter int          FRAMES_PER_COL = 20,
   parameter logic [31:0] SYNC_WORD      = SYNC_WORD_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 resetn,
   config_word_parser_if.slave  bus
);

   parser_state_e state_q, state_d;

   logic       strobe;
   logic       word_is_sync;
   logic [7:0] word_col;
   logic [7:0] word_idx;
   logic       hdr_bad;

   logic       hdr_load;
   logic       data_wr;
   logic       hunt_sync;

   logic [7:0] hdr_col_q;
   logic [7:0] hdr_idx_q;
   logic       discard_q;
   logic       format_error_q;
   logic [7:0] frame_column_q;
   logic [7:0] frame_index_q;

   logic       last_row;
   logic       frame_strobe;
   logic       commit;

   assign strobe       = bus.SelfWriteStrobe;
   assign word_is_sync = (bus.SelfWriteData == SYNC_WORD);
   assign word_col     = hdr_column(bus.SelfWriteData);
   assign word_idx     = hdr_index(bus.SelfWriteData);

   // Range checks on the 8-bit fields, zero-extended.
   assign hdr_bad = ({24'd0, word_col} >= 32'(NUM_COLUMNS)) ||
                    ({24'd0, word_idx} >= 32'(FRAMES_PER_COL));

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) state_q <= HUNT;
      else         state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      hdr_load  = 1'b0;
      data_wr   = 1'b0;
      hunt_sync = 1'b0;
      case (state_q)
         HUNT: begin
            if (strobe && word_is_sync) begin
               state_d   = HEADER;
               hunt_sync = 1'b1;
            end
         end
         HEADER: begin
            // A repeated sync word in HEADER is a no-op.
            if (strobe && !word_is_sync) begin
               if (word_col == DESYNC_COLUMN) begin
                  state_d = HUNT;
               end else begin
                  hdr_load = 1'b1;
                  state_d  = DATA;
               end
            end
         end
         DATA: begin
            // Sync-valued words are ordinary data here.
            if (strobe) begin
               data_wr = 1'b1;
               if (last_row) state_d = HEADER;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   assign commit = data_wr && last_row && !discard_q;

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         hdr_col_q      <= '0;
         hdr_idx_q      <= '0;
         discard_q      <= 1'b0;
         format_error_q <= 1'b0;
         frame_column_q <= '0;
         frame_index_q  <= '0;
      end else begin
         if (hdr_load) begin
            hdr_col_q <= word_col;
            hdr_idx_q <= word_idx;
            discard_q <= hdr_bad;
            if (hdr_bad) format_error_q <= 1'b1;
         end
         // Column/index move only on commit, so they stay stable through the
         // following header and data words.
         if (commit) begin
            frame_column_q <= hdr_col_q;
            frame_index_q  <= hdr_idx_q;
         end
      end
   end

   config_frame_assembler #(
      .NUM_ROWS (NUM_ROWS)
   ) u_assembler (
      .CLK          (CLK),
      .resetn       (resetn),
      .clr          (hdr_load),
      .wr_en        (data_wr),
      .wr_data      (bus.SelfWriteData),
      .discard      (discard_q),
      .frame_data   (bus.FrameData),
      .last_row     (last_row),
      .frame_strobe (frame_strobe)
   );

   assign bus.FrameStrobe  = frame_strobe;
   assign bus.FrameColumn  = frame_column_q;
   assign bus.FrameIndex   = frame_index_q;
   assign bus.ConfigActive = (state_q != HUNT);
   assign bus.FormatError  = format_error_q;

`ifdef CONFIG_FRAME_COUNTER_EN
   logic [15:0] frame_count_q;

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         frame_count_q <= '0;
      end else if (hunt_sync) begin
         frame_count_q <= '0;
      end else if (frame_strobe && (frame_count_q != 16'hFFFF)) begin
         frame_count_q <= frame_count_q + 16'd1;
      end
   end

   assign bus.FrameCount = frame_count_q;
`else
   // hunt_sync only feeds the optional frame counter.
   logic unused_hunt_sync;
   assign unused_hunt_sync = hunt_sync;
`endif

endmodule
